mont_conversion_in: RTL



---
 rtl/mont_conversion_in_if.sv | 23 ++
 rtl/mont_conversion_in.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mont_conversion_in_if.sv
// Request/result bundle for the Montgomery-form input converter.
// The master side issues (x_in, N_in) requests; the slave side returns x_mont_out/err_out.
interface mont_conversion_in_if #(
    parameter int WIDTH = 512
);
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] N_in;
    logic             valid_out;
    logic [WIDTH-1:0] x_mont_out;
    logic             err_out;

    modport master (
        output valid_in, x_in, N_in,
        input  ready_out, valid_out, x_mont_out, err_out
    );

    modport slave (
        input  valid_in, x_in, N_in,
        output ready_out, valid_out, x_mont_out, err_out
    );
endinterface

// File: rtl/mont_conversion_in.sv
// Montgomery-form entry converter: x_mont = x * 2^WIDTH mod N, computed by
// WIDTH modular doublings, one per cycle, with a single request in flight.
module mont_conversion_in #(
    parameter int WIDTH = 512
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    mont_conversion_in_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        DOUBLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_flag_q, err_flag_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    // One modular doubling step. Since a < n, 2a <= 2n-2 fits in WIDTH+1 bits,
    // and a single conditional subtraction restores a < n.
    function automatic logic [WIDTH:0] mod_double(input logic [WIDTH:0] a,
                                                  input logic [WIDTH-1:0] n);
        logic [WIDTH:0] t;
        logic [WIDTH:0] n_ext;
        t     = {a[WIDTH-1:0], 1'b0};
        n_ext = {1'b0, n};
        if (t >= n_ext) begin
            return t - n_ext;
        end
        return t;
    endfunction

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            valid_q    <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            valid_q    <= valid_d;
            res_q      <= res_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath control: capture, validate, iterate, publish.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        valid_d    = 1'b0;
        res_d      = res_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    acc_d   = {1'b0, bus.x_in};
                    n_d     = bus.N_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Even modulus (including 0) or an unreduced operand is rejected.
                if (!n_q[0] || (acc_q >= {1'b0, n_q})) begin
                    err_flag_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    err_flag_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = DOUBLE;
                end
            end
            DOUBLE: begin
                acc_d = mod_double(acc_q, n_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Outputs change only here, so they hold between completions.
                valid_d = 1'b1;
                res_d   = err_flag_q ? '0 : acc_q[WIDTH-1:0];
                err_d   = err_flag_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready_out  = rst_in & (state_q == IDLE);
    assign bus.valid_out  = valid_q;
    assign bus.x_mont_out = res_q;
    assign bus.err_out    = err_q;

endmodule
